common_ram_sdp_ctrl: RTL and testbench

COMMON_RAM_SDP_CTRL -- requirements
Module: common_ram_sdp_ctrl

---
 rtl/common_ram_sdp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_common_ram_sdp_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/common_ram_sdp_ctrl.sv
// Simple dual-port RAM controller: one write port with 9-bit column enables,
// one fully pipelined read port (1 or 2 cycles latency), and an optional
// post-reset sweep that fills the whole array with CLEAR_VALUE.
module common_ram_sdp_ctrl #(
  parameter int unsigned      DSIZE          = 36,
  parameter int unsigned      ASIZE          = 12,
  parameter int unsigned      RD_LAT         = 2,
  parameter int unsigned      CLEAR_ON_RESET = 1,
  parameter logic [DSIZE-1:0] CLEAR_VALUE    = '0,
  localparam int unsigned     NB_COL         = (DSIZE + 8) / 9
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [NB_COL-1:0] wr_col,
  input  logic [ASIZE-1:0]  wr_addr,
  input  logic [DSIZE-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ASIZE-1:0]  rd_addr,
  output logic [DSIZE-1:0]  rd_data,
  output logic              rd_vld,
  output logic              init_busy
);

  localparam int unsigned      DEPTH     = 2 ** ASIZE;
  localparam logic [ASIZE-1:0] ADDR_LAST = '1;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]       state;
  logic [ASIZE-1:0] clr_addr;
  logic             ready;
  logic             clearing;
  logic             wr_accept;
  logic             rd_accept;

  // Shared physical write port: the clear sweep or the user write
  logic              mem_we;
  logic [NB_COL-1:0] mem_col;
  logic [ASIZE-1:0]  mem_addr;
  logic [DSIZE-1:0]  mem_wdata;

  // Read word after write-first column merge, before the output pipeline
  logic [DSIZE-1:0]  rd_word;

  // Control FSM: RST -> (CLEAR sweep) -> READY; rst always forces RST
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= ST_RST;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_RST: begin
          clr_addr <= '0;
          state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end
        ST_CLEAR: begin
          // Last address written this cycle; the counter never wraps
          if (clr_addr == ADDR_LAST) begin
            state <= ST_READY;
          end else begin
            clr_addr <= clr_addr + ASIZE'(1);
          end
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_RST;
      endcase
    end
  end

  assign ready     = (state == ST_READY);
  assign clearing  = (state == ST_CLEAR);
  assign init_busy = (CLEAR_ON_RESET != 0) && !ready;

  // User requests are only honoured once the array is initialised
  assign wr_accept = wr_en && ready;
  assign rd_accept = rd_en && ready;

  // Write-port steering between the clear sweep and user writes
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mem_we    = 1'b0;
    mem_col   = '0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    if (clearing) begin
      mem_we    = 1'b1;
      mem_col   = '1;
      mem_addr  = clr_addr;
      mem_wdata = CLEAR_VALUE;
    end else if (wr_accept) begin
      mem_we  = 1'b1;
      mem_col = wr_col;
    end
  end

  // One narrow array per 9-bit column so each column writes independently;
  // the top column is truncated to whatever bits remain of DSIZE.
  for (genvar c = 0; c < NB_COL; c++) begin : g_col
    localparam int LO = c * 9;
    localparam int W  = (int'(DSIZE) - LO < 9) ? int'(DSIZE) - LO : 9;

    logic [W-1:0] mem [DEPTH];
    logic         wr_hit;

    // Column storage write
    always_ff @(posedge clock) begin
      // NOTE: the array has no reset; only the clear sweep initialises it,
      // which keeps it mappable onto block RAM.
      if (mem_we && mem_col[c]) begin
        mem[mem_addr] <= mem_wdata[LO +: W];
      end
    end

    // Write-first per column: a same-cycle write to this column bypasses
    assign wr_hit            = wr_accept && wr_col[c] && (wr_addr == rd_addr);
    assign rd_word[LO +: W]  = wr_hit ? wr_data[LO +: W] : mem[rd_addr];
  end

  if (RD_LAT == 1) begin : g_lat1
    // Single output register; rd_data holds between valid reads
    always_ff @(posedge clock) begin
      if (rst) begin
        rd_vld  <= 1'b0;
        rd_data <= '0;
      end else begin
        rd_vld <= rd_accept;
        if (rd_accept) begin
          rd_data <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic             s1_vld;
    logic [DSIZE-1:0] s1_data;

    // Two-stage read pipeline; reset drops any reads in flight
    always_ff @(posedge clock) begin
      if (rst) begin
        s1_vld  <= 1'b0;
        rd_vld  <= 1'b0;
        rd_data <= '0;
      end else begin
        s1_vld <= rd_accept;
        if (rd_accept) begin
          s1_data <= rd_word;
        end
        rd_vld <= s1_vld;
        if (s1_vld) begin
          rd_data <= s1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_common_ram_sdp_ctrl.sv
// Bench for common_ram_sdp_ctrl: two instances (read latency 2 with zero
// clear value, read latency 1 with a patterned clear value) share one set of
// inputs. A cycle-level behavioural model predicts every output; a few
// literal expectations pin the key scenarios independently of the model.
module tb_common_ram_sdp_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [35:0] CV1   = 36'h5_A5A5_A5A5;
  localparam logic [35:0] BASE  = 36'h1_1111_1111;

  logic        clock = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [3:0]  wr_addr;
  logic [35:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [35:0] rd_data0, rd_data1;
  logic        rd_vld0, rd_vld1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  common_ram_sdp_ctrl #(
    .DSIZE(36), .ASIZE(4), .RD_LAT(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(36'h0)
  ) u0 (
    .clock(clock), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_vld(rd_vld0), .init_busy(busy0)
  );

  common_ram_sdp_ctrl #(
    .DSIZE(36), .ASIZE(4), .RD_LAT(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV1)
  ) u1 (
    .clock(clock), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_vld(rd_vld1), .init_busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n_rel counts clock edges since the last edge that saw rst high.
  // Edge n=1 starts the sweep, edges n=1..16 clear address n-1, so the array
  // is busy while n<=16 and requests are accepted on edges where n>16.
  int          lat_of [2] = '{2, 1};
  logic [35:0] cv     [2];
  logic [35:0] mm     [2][DEPTH];
  int          n_rel  [2];
  logic        dv     [2][2];
  logic [35:0] dd     [2][2];
  logic        ev     [2];
  logic [35:0] ed     [2];

  task automatic model_step(input int i);
    logic        nv;
    logic [35:0] nd;
    bit          rdy;
    if (rst) begin
      n_rel[i] = 0;
      dv[i][0] = 1'b0;
      dv[i][1] = 1'b0;
      ev[i]    = 1'b0;
      ed[i]    = '0;
    end else begin
      rdy = (n_rel[i] > DEPTH);
      if (n_rel[i] >= 1 && n_rel[i] <= DEPTH) mm[i][n_rel[i]-1] = cv[i];
      if (rdy && wr_en) begin
        for (int c = 0; c < 4; c++) begin
          if (wr_col[c]) mm[i][wr_addr][c*9 +: 9] = wr_data[c*9 +: 9];
        end
      end
      nv = rdy && rd_en;
      nd = mm[i][rd_addr];
      if (lat_of[i] == 2) begin
        dv[i][0] = dv[i][1];
        dd[i][0] = dd[i][1];
        dv[i][1] = nv;
        dd[i][1] = nd;
      end else begin
        dv[i][0] = nv;
        dd[i][0] = nd;
      end
      ev[i] = dv[i][0];
      if (dv[i][0]) ed[i] = dd[i][0];
      if (n_rel[i] < 1000) n_rel[i]++;
    end
  endtask

  task automatic compare_all();
    check("u0_init_busy", 64'(busy0),    64'(n_rel[0] <= DEPTH));
    check("u1_init_busy", 64'(busy1),    64'(n_rel[1] <= DEPTH));
    check("u0_rd_vld",    64'(rd_vld0),  64'(ev[0]));
    check("u1_rd_vld",    64'(rd_vld1),  64'(ev[1]));
    check("u0_rd_data",   64'(rd_data0), 64'(ed[0]));
    check("u1_rd_data",   64'(rd_data1), 64'(ed[1]));
  endtask

  // Model advances on each edge from the inputs the DUT samples there;
  // outputs are compared half a cycle later.
  initial begin
    cv[0] = '0;
    cv[1] = CV1;
    for (int i = 0; i < 2; i++) begin
      n_rel[i] = 0;
      dv[i][0] = 1'b0;
      dv[i][1] = 1'b0;
      ev[i]    = 1'b0;
      ed[i]    = '0;
    end
    forever begin
      @(posedge clock);
      model_step(0);
      model_step(1);
      @(negedge clock);
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts half-cycle samples with init_busy high, starting just after the
  // edge that first sees rst low; bounded so a stuck sweep cannot hang.
  task automatic count_sweep(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!busy0) break;
      cnt++;
    end
  endtask

  int          busy_cnt;
  logic [35:0] want;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_col = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    @(negedge clock);
    check("reset_rd_vld",  64'(rd_vld0),  64'(0));
    check("reset_rd_data", 64'(rd_data0), 64'(0));
    check("reset_busy",    64'(busy0),    64'(1));

    // Release with both requests held high for the whole sweep
    tick();
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b1; wr_col = 4'hF;
    wr_data = 36'hF_FFFF_FFFF; wr_addr = 4'd5; rd_addr = 4'd5;
    tick();
    count_sweep(busy_cnt);
    rd_en = 1'b0; wr_en = 1'b0;
    check("sweep_len", 64'(busy_cnt), 64'(16));

    // Read every address back: clear value everywhere
    for (int a = 0; a < DEPTH; a++) begin
      tick();
      rd_en = 1'b1; rd_addr = 4'(a);
    end
    tick();
    rd_en = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("clear_u0_last", 64'(rd_data0), 64'(36'h0));
    check("clear_u1_last", 64'(rd_data1), 64'(CV1));

    // Write then read one cycle later, latency 1 and 2
    tick();
    wr_en = 1'b1; wr_col = 4'hF; wr_addr = 4'd5; wr_data = 36'hA_BCDE_F012;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    @(negedge clock);
    check("lat2_not_yet", 64'(rd_vld0),  64'(0));
    check("lat1_vld",     64'(rd_vld1),  64'(1));
    check("lat1_data",    64'(rd_data1), 64'(36'hA_BCDE_F012));
    tick();
    @(negedge clock);
    check("lat2_vld",  64'(rd_vld0),  64'(1));
    check("lat2_data", 64'(rd_data0), 64'(36'hA_BCDE_F012));

    // Same-cycle partial write and read: columns 0,2 new, 1,3 old
    tick();
    wr_en = 1'b1; wr_col = 4'hF; wr_addr = 4'd3; wr_data = 36'h1_1111_1111;
    tick();
    wr_col = 4'b0101; wr_data = 36'hF_FFFF_FFFF; rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clock);
    check("merge_u1", 64'(rd_data1), 64'(36'h1_17FD_11FF));
    tick();
    @(negedge clock);
    check("merge_u0", 64'(rd_data0), 64'(36'h1_17FD_11FF));
    tick();
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;

    // A write issued after the read cycle must not leak into that read
    wr_en = 1'b1; wr_col = 4'hF; wr_addr = 4'd7; wr_data = 36'h1_2345_6789;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 36'h9_8765_4321;
    tick();
    wr_en = 1'b0;
    @(negedge clock);
    check("late_write_vld",  64'(rd_vld0),  64'(1));
    check("late_write_data", 64'(rd_data0), 64'(36'h1_2345_6789));

    // Fill 8..15, a wr_col=0 no-op on 8, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      tick();
      wr_en = 1'b1; wr_col = 4'hF; wr_addr = 4'(8 + i); wr_data = BASE * 36'(i + 1);
    end
    tick();
    wr_col = 4'h0; wr_addr = 4'd8; wr_data = 36'hF_FFFF_FFFF;
    tick();
    wr_en = 1'b0; wr_col = 4'hF;
    for (int j = 0; j <= 8; j++) begin
      tick();
      if (j < 8) begin
        rd_en = 1'b1; rd_addr = 4'(8 + j);
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clock);
      if (j >= 1) begin
        want = BASE * 36'(j);
        check("burst_vld",  64'(rd_vld1),  64'(1));
        check("burst_data", 64'(rd_data1), 64'(want));
      end
    end
    repeat (3) tick();

    // Reset with a read in flight on the latency-2 instance
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clock);
    check("flush_vld",  64'(rd_vld0),  64'(0));
    check("flush_data", 64'(rd_data0), 64'(0));

    // Interrupt the sweep at count 7; it must restart and run 16 cycles
    tick();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    count_sweep(busy_cnt);
    check("restart_sweep_len", 64'(busy_cnt), 64'(16));
    tick();
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    @(negedge clock);
    check("recleared_u1", 64'(rd_data1), 64'(CV1));
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
